// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller (one word per line).
// Define DCACHE_STATS_EN to build the hit/miss statistics counters; otherwise they read as zero.
module dcache_ctrl #(
  parameter int LINE_BITS  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_din,
  output logic [31:0]           cpu_dout,
  output logic                  cpu_stall,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  localparam int NUM_LINES = 1 << LINE_BITS;
  localparam int TAG_W     = ADDR_WIDTH - LINE_BITS - 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_FILL = 2'd2} state_t;
  state_t state_r, state_s;

  logic [NUM_LINES-1:0]  valid_r, dirty_r;
  logic [TAG_W-1:0]      tag_r  [NUM_LINES];
  logic [31:0]           data_r [NUM_LINES];
  // Word address of the miss in service, so the victim/fill line stays fixed even if the CPU lets go.
  logic [ADDR_WIDTH-3:0] miss_word_r;

  logic [LINE_BITS-1:0]  index_s, miss_index_s;
  logic [TAG_W-1:0]      tag_s;
  logic                  hit_s, miss_s, write_hit_s, wb_done_s, fill_done_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic                  unused_addr_s;

  assign index_s       = cpu_addr[LINE_BITS+1:2];
  assign tag_s         = cpu_addr[ADDR_WIDTH-1:LINE_BITS+2];
  assign miss_index_s  = miss_word_r[LINE_BITS-1:0];
  assign hit_s         = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign miss_s        = (state_r == S_IDLE) && cpu_req && !hit_s;
  assign write_hit_s   = (state_r == S_IDLE) && cpu_req && cpu_we && hit_s;
  assign wb_done_s     = (state_r == S_WB) && mem_ack;
  assign fill_done_s   = (state_r == S_FILL) && mem_ack;
  assign unused_addr_s = ^cpu_addr[1:0];

  // State register, miss address latch and per-line valid/dirty bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      valid_r     <= {NUM_LINES{1'b0}};
      dirty_r     <= {NUM_LINES{1'b0}};
      miss_word_r <= {(ADDR_WIDTH-2){1'b0}};
    end else begin
      state_r <= state_s;
      if (miss_s) miss_word_r <= cpu_addr[ADDR_WIDTH-1:2];
      if (write_hit_s) dirty_r[index_s] <= 1'b1;
      if (wb_done_s) dirty_r[miss_index_s] <= 1'b0;
      if (fill_done_s) begin
        valid_r[miss_index_s] <= 1'b1;
        dirty_r[miss_index_s] <= 1'b0;
      end
    end
  end

  // Tag and data storage; contents are only meaningful where valid is set
  always_ff @(posedge clk) begin
    if (write_hit_s) begin
      data_r[index_s] <= cpu_din;
    end else if (fill_done_s) begin
      data_r[miss_index_s] <= mem_dout;
      tag_r[miss_index_s]  <= miss_word_r[ADDR_WIDTH-3:LINE_BITS];
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (miss_s) state_s = (valid_r[index_s] && dirty_r[index_s]) ? S_WB : S_FILL;
        else        state_s = S_IDLE;
      end
      S_WB: begin
        if (mem_ack) state_s = S_FILL;
        else         state_s = S_WB;
      end
      S_FILL: begin
        if (mem_ack) state_s = S_IDLE;
        else         state_s = S_FILL;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    cpu_stall  = 1'b0;
    cpu_dout   = 32'd0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr_s = {ADDR_WIDTH{1'b0}};
    mem_din    = 32'd0;
    if (rst) begin
      case (state_r)
        S_IDLE: begin
          cpu_stall = cpu_req && !hit_s;
          if (cpu_req && !cpu_we && hit_s) cpu_dout = data_r[index_s];
          else                             cpu_dout = 32'd0;
        end
        S_WB: begin
          cpu_stall  = 1'b1;
          mem_cs     = !mem_ack;
          mem_we     = 1'b1;
          mem_addr_s = {tag_r[miss_index_s], miss_index_s, 2'b00};
          mem_din    = data_r[miss_index_s];
        end
        S_FILL: begin
          cpu_stall  = 1'b1;
          mem_cs     = !mem_ack;
          mem_addr_s = {miss_word_r, 2'b00};
        end
        default: begin
          cpu_stall = 1'b0;
        end
      endcase
    end else begin
      cpu_stall = 1'b0;
    end
  end

  assign mem_addr = 32'(mem_addr_s);

`ifdef DCACHE_STATS_EN
  logic        refill_r;
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Statistics; refill_r masks the post-fill completion so it is not counted as a hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refill_r   <= 1'b0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (fill_done_s)               refill_r <= 1'b1;
      else if (state_r == S_IDLE)    refill_r <= 1'b0;
      if ((state_r == S_IDLE) && cpu_req && hit_s && !refill_r) hit_cnt_r <= hit_cnt_r + 32'd1;
      if (miss_s) miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized traffic against a
// line-level reference model and a behavioural multi-cycle RAM.
module tb_dcache_ctrl;
  localparam int LINES = 16;

  logic        clk = 1'b0, rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_din = 32'd0;
  logic [31:0] cpu_dout, mem_addr, mem_din, hit_cnt, miss_cnt;
  logic        cpu_stall, mem_cs, mem_we;
  logic [31:0] mem_dout = 32'd0;
  logic        mem_ack = 1'b0;

  int checks = 0, errors = 0;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return w ^ 32'hA5C3_0F1E;
  endfunction

  // RAM: ack in the cycle after the 4th cs-high cycle; bus sampled on the falling edge
  logic [31:0] ram [int unsigned];
  int          ram_cnt = 0, wb_cnt = 0, fill_cnt = 0, cs_cycles = 0, cs_ack_err = 0;
  logic        ack_next = 1'b0;
  logic [31:0] dout_next = 32'd0, last_wb_addr = 32'd0, last_wb_data = 32'd0, last_fill_addr = 32'd0;

  always @(negedge clk) begin
    ack_next = 1'b0;
    if (mem_ack && mem_cs) cs_ack_err++;
    if (!rst) begin
      ram_cnt = 0;
    end else if (mem_cs) begin
      cs_cycles++;
      ram_cnt++;
      if (ram_cnt == 4) begin
        ram_cnt  = 0;
        ack_next = 1'b1;
        if (mem_we) begin
          ram[mem_addr >> 2] = mem_din;
          wb_cnt++;
          last_wb_addr = mem_addr;
          last_wb_data = mem_din;
        end else begin
          dout_next = ram.exists(mem_addr >> 2) ? ram[mem_addr >> 2] : init_word(mem_addr);
          fill_cnt++;
          last_fill_addr = mem_addr;
        end
      end
    end else begin
      ram_cnt = 0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) mem_ack <= 1'b0;
    else begin
      mem_ack  <= ack_next;
      mem_dout <= dout_next;
    end
  end

  // Reference model: one entry per line, memory image as a word-keyed array
  logic        mv [LINES];
  logic        md [LINES];
  logic [31:0] mt [LINES];
  logic [31:0] mdat [LINES];
  logic [31:0] ref_mem [int unsigned];
  int          exp_hits = 0, exp_misses = 0;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] din,
                       output int stalls, output logic [31:0] dout, output bit wb,
                       output logic [31:0] wb_addr, output logic [31:0] wb_data);
    int unsigned i;
    logic [31:0] tg;
    i = (addr >> 2) % LINES;
    tg = addr >> 6;
    wb = 1'b0; wb_addr = 32'd0; wb_data = 32'd0; dout = 32'd0;
    if (mv[i] && mt[i] == tg) begin
      stalls = 0;
      exp_hits++;
    end else begin
      exp_misses++;
      if (mv[i] && md[i]) begin
        wb = 1'b1;
        wb_addr = mt[i] * 64 + i * 4;
        wb_data = mdat[i];
        ref_mem[wb_addr >> 2] = wb_data;
        stalls = 11;
      end else begin
        stalls = 6;
      end
      mdat[i] = ref_mem.exists(addr >> 2) ? ref_mem[addr >> 2] : init_word(addr);
      mv[i] = 1'b1;
      mt[i] = tg;
      md[i] = 1'b0;
    end
    if (we) begin
      mdat[i] = din;
      md[i] = 1'b1;
    end else begin
      dout = mdat[i];
    end
  endtask

  // Drive one request from a falling edge, hold it through the stall, leave at the next falling edge
  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] din,
                      output int stalls, output logic [31:0] dout, output bit bus_busy,
                      output int es, output logic [31:0] ed, output bit ewb,
                      output logic [31:0] ewa, output logic [31:0] ewd);
    model(we, addr, din, es, ed, ewb, ewa, ewd);
    stalls = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    #1;
    while (cpu_stall && stalls <= 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    dout = cpu_dout;
    bus_busy = mem_cs | mem_we | (|mem_addr) | (|mem_din);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  int          st, es, w0, f0, c0;
  logic [31:0] d, ed, ewa, ewd;
  bit          busy, ewb;

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", cpu_stall); end
    checks++; if (cpu_dout !== 32'd0) begin errors++; $display("FAIL reset_dout: got %0h expected 0", cpu_dout); end
    checks++; if (mem_cs !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_cs_we: got %0b%0b expected 00", mem_cs, mem_we); end
    checks++; if (mem_addr !== 32'd0 || mem_din !== 32'd0) begin errors++; $display("FAIL reset_bus: got %0h/%0h expected 0/0", mem_addr, mem_din); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_counters(input string tag);
`ifdef DCACHE_STATS_EN
    checks++; if (hit_cnt !== 32'(exp_hits)) begin errors++; $display("FAIL %s_hit_cnt: got %0d expected %0d", tag, hit_cnt, exp_hits); end
    checks++; if (miss_cnt !== 32'(exp_misses)) begin errors++; $display("FAIL %s_miss_cnt: got %0d expected %0d", tag, miss_cnt, exp_misses); end
`else
    checks++; if (hit_cnt !== 32'd0) begin errors++; $display("FAIL %s_hit_cnt: got %0d expected 0", tag, hit_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL %s_miss_cnt: got %0d expected 0", tag, miss_cnt); end
`endif
  endtask

  task automatic test_clean_miss();
    w0 = wb_cnt; f0 = fill_cnt; c0 = cs_cycles;
    step(1'b0, 32'h40, 32'd0, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 6) begin errors++; $display("FAIL clean_stalls: got %0d expected 6", st); end
    checks++; if (d !== init_word(32'h40)) begin errors++; $display("FAIL clean_dout: got %0h expected %0h", d, init_word(32'h40)); end
    checks++; if (fill_cnt - f0 !== 1 || last_fill_addr !== 32'h40) begin errors++; $display("FAIL clean_fill: got %0d@%0h expected 1@40", fill_cnt - f0, last_fill_addr); end
    checks++; if (wb_cnt - w0 !== 0 || cs_cycles - c0 !== 4) begin errors++; $display("FAIL clean_traffic: got wb %0d cs %0d expected wb 0 cs 4", wb_cnt - w0, cs_cycles - c0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_idle_bus: got %0b expected 0", busy); end
    test_counters("clean");
  endtask

  task automatic test_hit();
    c0 = cs_cycles;
    step(1'b0, 32'h40, 32'd0, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 0) begin errors++; $display("FAIL hit_stalls: got %0d expected 0", st); end
    checks++; if (d !== init_word(32'h40)) begin errors++; $display("FAIL hit_dout: got %0h expected %0h", d, init_word(32'h40)); end
    checks++; if (cs_cycles !== c0 || busy !== 1'b0) begin errors++; $display("FAIL hit_no_traffic: got cs %0d busy %0b expected 0 0", cs_cycles - c0, busy); end
    test_counters("hit");
  endtask

  task automatic test_write_hit();
    c0 = cs_cycles;
    step(1'b1, 32'h40, 32'hDEADBEEF, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 0 || d !== 32'd0) begin errors++; $display("FAIL wr_hit: got stall %0d dout %0h expected 0 0", st, d); end
    step(1'b0, 32'h40, 32'd0, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 0 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_readback: got stall %0d dout %0h expected 0 deadbeef", st, d); end
    checks++; if (cs_cycles !== c0) begin errors++; $display("FAIL wr_no_traffic: got %0d expected 0", cs_cycles - c0); end
  endtask

  task automatic test_dirty_miss();
    w0 = wb_cnt; f0 = fill_cnt; c0 = cs_cycles;
    step(1'b0, 32'h80, 32'd0, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 11) begin errors++; $display("FAIL dirty_stalls: got %0d expected 11", st); end
    checks++; if (wb_cnt - w0 !== 1 || last_wb_addr !== 32'h40 || last_wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL dirty_wb: got %0d %0h=%0h expected 1 40=deadbeef", wb_cnt - w0, last_wb_addr, last_wb_data); end
    checks++; if (fill_cnt - f0 !== 1 || last_fill_addr !== 32'h80 || cs_cycles - c0 !== 8) begin errors++; $display("FAIL dirty_fill: got %0d@%0h cs %0d expected 1@80 cs 8", fill_cnt - f0, last_fill_addr, cs_cycles - c0); end
    checks++; if (d !== init_word(32'h80)) begin errors++; $display("FAIL dirty_dout: got %0h expected %0h", d, init_word(32'h80)); end
    checks++; if (cs_ack_err !== 0) begin errors++; $display("FAIL cs_in_ack: got %0d expected 0", cs_ack_err); end
  endtask

  task automatic test_write_miss();
    w0 = wb_cnt;
    step(1'b1, 32'h100, 32'h12345678, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 6 || wb_cnt !== w0) begin errors++; $display("FAIL wmiss_alloc: got stall %0d wb %0d expected 6 0", st, wb_cnt - w0); end
    step(1'b0, 32'h100, 32'd0, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 0 || d !== 32'h12345678) begin errors++; $display("FAIL wmiss_merge: got stall %0d dout %0h expected 0 12345678", st, d); end
    step(1'b0, 32'h140, 32'd0, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 11 || last_wb_addr !== 32'h100 || last_wb_data !== 32'h12345678) begin errors++; $display("FAIL wmiss_evict: got stall %0d %0h=%0h expected 11 100=12345678", st, last_wb_addr, last_wb_data); end
  endtask

  task automatic test_reset_mid_fill();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h240;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mem_cs !== 1'b1) begin errors++; $display("FAIL midfill_cs_before: got %0b expected 1", mem_cs); end
    rst = 1'b0;
    #1;
    checks++; if (mem_cs !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL midfill_async: got cs %0b stall %0b expected 0 0", mem_cs, cpu_stall); end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    f0 = fill_cnt;
    step(1'b0, 32'h240, 32'd0, st, d, busy, es, ed, ewb, ewa, ewd);
    checks++; if (st !== 6 || fill_cnt - f0 !== 1) begin errors++; $display("FAIL midfill_remiss: got stall %0d fills %0d expected 6 1", st, fill_cnt - f0); end
    checks++; if (d !== ed) begin errors++; $display("FAIL midfill_dout: got %0h expected %0h", d, ed); end
    test_counters("midfill");
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr, din;
    for (int n = 0; n < 200; n++) begin
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      din  = $urandom();
      w0 = wb_cnt;
      step(we, addr, din, st, d, busy, es, ed, ewb, ewa, ewd);
      checks++; if (st !== es) begin errors++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", n, st, es); end
      checks++; if (d !== ed) begin errors++; $display("FAIL rand_dout[%0d]: got %0h expected %0h", n, d, ed); end
      checks++; if ((wb_cnt - w0) !== (ewb ? 1 : 0) || busy !== 1'b0) begin errors++; $display("FAIL rand_wb_count[%0d]: got %0d busy %0b expected %0d 0", n, wb_cnt - w0, busy, ewb ? 1 : 0); end
      if (ewb) begin
        checks++; if (last_wb_addr !== ewa || last_wb_data !== ewd) begin errors++; $display("FAIL rand_wb[%0d]: got %0h=%0h expected %0h=%0h", n, last_wb_addr, last_wb_data, ewa, ewd); end
      end
    end
    checks++; if (cs_ack_err !== 0) begin errors++; $display("FAIL rand_cs_in_ack: got %0d expected 0", cs_ack_err); end
    test_counters("rand");
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_hit();
    test_write_hit();
    test_dirty_miss();
    test_write_miss();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
